// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_hazard_ctrl                                                     |
// | Stall/flush sequencer for the 5-stage pipeline. The optional performance |
// | counters are enabled with the HZ_PERF_CNT_EN macro.                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipeline_hazard_ctrl #(
  parameter int AWIDTH       = 5,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_WIDTH    = 32
) (
  input  logic              hz_clk,
  input  logic              hz_rst,
  input  logic              hz_i_ce,
  input  logic              hz_i_ext_stall,
  input  logic              hz_i_ext_flush,
  input  logic              hz_i_ds_valid,
  input  logic [AWIDTH-1:0] hz_i_ds_addr_rs1,
  input  logic [AWIDTH-1:0] hz_i_ds_addr_rs2,
  input  logic              hz_i_es_valid,
  input  logic              hz_i_es_is_load,
  input  logic [AWIDTH-1:0] hz_i_es_addr_rd,
  input  logic              hz_i_es_change_pc,
  input  logic              hz_i_ms_busy,
  output logic              hz_o_fs_stall,
  output logic              hz_o_ds_stall,
  output logic              hz_o_es_stall,
  output logic              hz_o_ms_stall,
  output logic              hz_o_ws_stall,
  output logic              hz_o_ds_flush,
  output logic              hz_o_es_flush,
  output logic              hz_o_ms_flush,
  output logic [1:0]        hz_o_state,
  output logic              hz_o_timeout
`ifdef HZ_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] hz_o_stall_cnt,
  output logic [CNT_WIDTH-1:0] hz_o_flush_cnt
`endif
);

  localparam int c_seq_max = (LOAD_LAT > FLUSH_CYCLES) ? LOAD_LAT : FLUSH_CYCLES;
  localparam int c_seq_w   = $clog2(c_seq_max + 1);
  localparam int c_wait_w  = $clog2(MEM_TIMEOUT + 1);

  localparam logic [c_seq_w-1:0]  c_seq_one     = c_seq_w'(1);
  localparam logic [c_seq_w-1:0]  c_load_reload = c_seq_w'(LOAD_LAT - 1);
  localparam logic [c_seq_w-1:0]  c_flsh_reload = c_seq_w'(FLUSH_CYCLES - 1);
  localparam logic [c_wait_w-1:0] c_wait_one    = c_wait_w'(1);
  localparam logic [c_wait_w-1:0] c_wait_last   = c_wait_w'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_LOAD_STALL = 2'd1,
    S_FLUSH      = 2'd2,
    S_MEM_WAIT   = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [c_seq_w-1:0]  r_seq_cnt, w_seq_nxt;
  logic [c_wait_w-1:0] r_wait_cnt, w_wait_nxt;
  logic                r_pending, w_pend_nxt;
  logic                w_hazard, w_redir_req, w_seq_last;

  assign w_hazard = hz_i_es_valid & hz_i_es_is_load & (hz_i_es_addr_rd != '0) & hz_i_ds_valid &
                    ((hz_i_es_addr_rd == hz_i_ds_addr_rs1) | (hz_i_es_addr_rd == hz_i_ds_addr_rs2));
  // A redirect deferred during a memory wait is replayed once the memory is ready.
  assign w_redir_req = hz_i_es_change_pc | ((r_state == S_MEM_WAIT) & r_pending);
  assign w_seq_last  = (r_seq_cnt <= c_seq_one);
  assign hz_o_state  = r_state;

  always_comb begin
    hz_o_fs_stall = 1'b0;
    hz_o_ds_stall = 1'b0;
    hz_o_es_stall = 1'b0;
    hz_o_ms_stall = 1'b0;
    hz_o_ws_stall = 1'b0;
    hz_o_ds_flush = 1'b0;
    hz_o_es_flush = 1'b0;
    hz_o_ms_flush = 1'b0;
    hz_o_timeout  = 1'b0;
    w_state_nxt   = r_state;
    w_seq_nxt     = r_seq_cnt;
    w_wait_nxt    = r_wait_cnt;
    w_pend_nxt    = r_pending;
    if (hz_rst) begin
      if (!hz_i_ce) begin
        {hz_o_fs_stall, hz_o_ds_stall, hz_o_es_stall, hz_o_ms_stall, hz_o_ws_stall} = 5'b11111;
      end else if (hz_i_ext_flush) begin
        {hz_o_ds_flush, hz_o_es_flush, hz_o_ms_flush} = 3'b111;
        w_state_nxt = S_RUN;
        w_seq_nxt   = '0;
        w_wait_nxt  = '0;
        w_pend_nxt  = 1'b0;
      end else if (hz_i_ms_busy) begin
        {hz_o_fs_stall, hz_o_ds_stall, hz_o_es_stall} = 3'b111;
        w_seq_nxt = '0;
        if (r_wait_cnt >= c_wait_last) begin
          // Abort the stuck access: squash memory stage instead of stalling it.
          hz_o_ms_flush = 1'b1;
          hz_o_timeout  = 1'b1;
          w_state_nxt   = S_RUN;
          w_wait_nxt    = '0;
          w_pend_nxt    = 1'b0;
        end else begin
          hz_o_ms_stall = 1'b1;
          w_state_nxt   = S_MEM_WAIT;
          w_wait_nxt    = r_wait_cnt + c_wait_one;
          w_pend_nxt    = r_pending | hz_i_es_change_pc;
        end
      end else begin
        w_wait_nxt = '0;
        w_pend_nxt = 1'b0;
        if (w_redir_req) begin
          hz_o_ds_flush = 1'b1;
          hz_o_es_flush = 1'b1;
          w_state_nxt   = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
          w_seq_nxt     = c_flsh_reload;
        end else begin
          unique case (r_state)
            S_FLUSH, S_LOAD_STALL: begin
              if (r_state == S_FLUSH) begin
                hz_o_ds_flush = 1'b1;
              end else begin
                hz_o_fs_stall = 1'b1;
                hz_o_ds_stall = 1'b1;
              end
              hz_o_es_flush = 1'b1;
              if (w_seq_last) begin
                w_state_nxt = S_RUN;
                w_seq_nxt   = '0;
              end else begin
                w_seq_nxt = r_seq_cnt - c_seq_one;
              end
            end
            S_MEM_WAIT: w_state_nxt = S_RUN;
            default: begin
              if (w_hazard) begin
                hz_o_fs_stall = 1'b1;
                hz_o_ds_stall = 1'b1;
                hz_o_es_flush = 1'b1;
                w_state_nxt   = (LOAD_LAT > 1) ? S_LOAD_STALL : S_RUN;
                w_seq_nxt     = c_load_reload;
              end else if (hz_i_ext_stall) begin
                {hz_o_fs_stall, hz_o_ds_stall, hz_o_es_stall, hz_o_ms_stall, hz_o_ws_stall} = 5'b11111;
              end
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge hz_clk or negedge hz_rst) begin
    if (!hz_rst) begin
      r_state    <= S_RUN;
      r_seq_cnt  <= '0;
      r_wait_cnt <= '0;
      r_pending  <= 1'b0;
    end else if (hz_i_ce) begin
      r_state    <= w_state_nxt;
      r_seq_cnt  <= w_seq_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_pending  <= w_pend_nxt;
    end
  end

`ifdef HZ_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] r_stall_cnt, r_flush_cnt;
  logic                 w_any_stall, w_redirect_evt;

  assign w_any_stall    = hz_o_fs_stall | hz_o_ds_stall | hz_o_es_stall | hz_o_ms_stall | hz_o_ws_stall;
  assign w_redirect_evt = hz_i_ext_flush | (~hz_i_ms_busy & w_redir_req);

  always_ff @(posedge hz_clk or negedge hz_rst) begin
    if (!hz_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (hz_i_ce) begin
      if (w_any_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + c_cnt_one;
      if (w_redirect_evt && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + c_cnt_one;
    end
  end

  assign hz_o_stall_cnt = r_stall_cnt;
  assign hz_o_flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// Directed bench for pipeline_hazard_ctrl with default parameters; expected
// output vectors go through a scoreboard queue and are checked mid-cycle.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce, ext_stall, ext_flush, ds_valid, es_valid, es_is_load, change_pc, ms_busy;
  logic [4:0] rs1, rs2, es_rd;
  logic       fs_st, ds_st, es_st, ms_st, ws_st, ds_fl, es_fl, ms_fl, tmo;
  logic [1:0] state;
  logic [10:0] obs;
`ifdef HZ_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  typedef struct {
    string       tag;
    logic [10:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_pass = 0;
  int  n_fail = 0;
  int  n_total = 0;

  always #5 clk = ~clk;

  // Observed vector: {fs,ds,es,ms,ws stall, ds,es,ms flush, timeout, state}
  assign obs = {fs_st, ds_st, es_st, ms_st, ws_st, ds_fl, es_fl, ms_fl, tmo, state};

  pipeline_hazard_ctrl dut (
    .hz_clk            (clk),
    .hz_rst            (rst_n),
    .hz_i_ce           (ce),
    .hz_i_ext_stall    (ext_stall),
    .hz_i_ext_flush    (ext_flush),
    .hz_i_ds_valid     (ds_valid),
    .hz_i_ds_addr_rs1  (rs1),
    .hz_i_ds_addr_rs2  (rs2),
    .hz_i_es_valid     (es_valid),
    .hz_i_es_is_load   (es_is_load),
    .hz_i_es_addr_rd   (es_rd),
    .hz_i_es_change_pc (change_pc),
    .hz_i_ms_busy      (ms_busy),
    .hz_o_fs_stall     (fs_st),
    .hz_o_ds_stall     (ds_st),
    .hz_o_es_stall     (es_st),
    .hz_o_ms_stall     (ms_st),
    .hz_o_ws_stall     (ws_st),
    .hz_o_ds_flush     (ds_fl),
    .hz_o_es_flush     (es_fl),
    .hz_o_ms_flush     (ms_fl),
    .hz_o_state        (state),
    .hz_o_timeout      (tmo)
`ifdef HZ_PERF_CNT_EN
    ,
    .hz_o_stall_cnt    (stall_cnt),
    .hz_o_flush_cnt    (flush_cnt)
`endif
  );

  function automatic logic [10:0] ev(input logic [4:0] st, input logic [2:0] fl,
                                     input logic to, input logic [1:0] s);
    return {st, fl, to, s};
  endfunction

  task automatic idle();
    ce = 1'b1; ext_stall = 1'b0; ext_flush = 1'b0;
    ds_valid = 1'b0; rs1 = 5'd0; rs2 = 5'd0;
    es_valid = 1'b0; es_is_load = 1'b0; es_rd = 5'd0;
    change_pc = 1'b0; ms_busy = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    idle();
  endtask

  task automatic load_use(input logic [4:0] rd, input logic [4:0] a1, input logic [4:0] a2);
    es_valid = 1'b1; es_is_load = 1'b1; es_rd = rd;
    ds_valid = 1'b1; rs1 = a1; rs2 = a2;
  endtask

  task automatic expect_out(input string tag, input logic [10:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    n_total++;
    assert (obs === e.exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();

    next_cycle(); change_pc = 1'b1; load_use(5'd5, 5'd0, 5'd5); ms_busy = 1'b1;
    expect_out("reset_outputs_low", ev(5'b00000, 3'b000, 1'b0, 2'd0));
    next_cycle(); rst_n = 1'b1;
    expect_out("idle_after_reset", ev(5'b00000, 3'b000, 1'b0, 2'd0));

    next_cycle(); ce = 1'b0; change_pc = 1'b1; ms_busy = 1'b1;
    expect_out("ce_low_freeze", ev(5'b11111, 3'b000, 1'b0, 2'd0));

    // Load-use hazard, LOAD_LAT=1: single bubble cycle
    next_cycle(); load_use(5'd5, 5'd3, 5'd5);
    expect_out("hazard_rs2", ev(5'b11000, 3'b010, 1'b0, 2'd0));
    next_cycle();
    expect_out("hazard_released", ev(5'b00000, 3'b000, 1'b0, 2'd0));
    next_cycle(); load_use(5'd7, 5'd7, 5'd1);
    expect_out("hazard_rs1", ev(5'b11000, 3'b010, 1'b0, 2'd0));
    next_cycle(); load_use(5'd0, 5'd0, 5'd0);
    expect_out("hazard_rd_zero", ev(5'b00000, 3'b000, 1'b0, 2'd0));
    next_cycle(); load_use(5'd5, 5'd5, 5'd5); es_valid = 1'b0;
    expect_out("hazard_es_invalid", ev(5'b00000, 3'b000, 1'b0, 2'd0));

    next_cycle(); ext_stall = 1'b1;
    expect_out("ext_stall_run", ev(5'b11111, 3'b000, 1'b0, 2'd0));

    // Redirect with FLUSH_CYCLES=2
    next_cycle(); change_pc = 1'b1;
    expect_out("redirect", ev(5'b00000, 3'b110, 1'b0, 2'd0));
    next_cycle();
    expect_out("flush_hold", ev(5'b00000, 3'b110, 1'b0, 2'd2));
    next_cycle();
    expect_out("flush_done", ev(5'b00000, 3'b000, 1'b0, 2'd0));

    // Reload in FLUSH; ext_stall and hazard ignored there
    next_cycle(); change_pc = 1'b1;
    expect_out("redirect_2", ev(5'b00000, 3'b110, 1'b0, 2'd0));
    next_cycle(); change_pc = 1'b1;
    expect_out("flush_reload", ev(5'b00000, 3'b110, 1'b0, 2'd2));
    next_cycle(); ext_stall = 1'b1; load_use(5'd4, 5'd4, 5'd0);
    expect_out("flush_ignores_stall", ev(5'b00000, 3'b110, 1'b0, 2'd2));
    next_cycle();
    expect_out("flush_reload_done", ev(5'b00000, 3'b000, 1'b0, 2'd0));

    // ce=0 freezes the flush countdown
    next_cycle(); change_pc = 1'b1;
    expect_out("redirect_3", ev(5'b00000, 3'b110, 1'b0, 2'd0));
    next_cycle(); ce = 1'b0;
    expect_out("ce_low_in_flush", ev(5'b11111, 3'b000, 1'b0, 2'd2));
    next_cycle();
    expect_out("flush_after_freeze", ev(5'b00000, 3'b110, 1'b0, 2'd2));
    next_cycle();
    expect_out("run_after_freeze", ev(5'b00000, 3'b000, 1'b0, 2'd0));

    // Busy 3 cycles with a redirect in cycle 2
    next_cycle(); ms_busy = 1'b1;
    expect_out("busy_c1", ev(5'b11110, 3'b000, 1'b0, 2'd0));
    next_cycle(); ms_busy = 1'b1; change_pc = 1'b1;
    expect_out("busy_c2_pc", ev(5'b11110, 3'b000, 1'b0, 2'd3));
    next_cycle(); ms_busy = 1'b1;
    expect_out("busy_c3", ev(5'b11110, 3'b000, 1'b0, 2'd3));
    next_cycle();
    expect_out("busy_release_pending", ev(5'b00000, 3'b110, 1'b0, 2'd3));
    next_cycle();
    expect_out("pending_flush", ev(5'b00000, 3'b110, 1'b0, 2'd2));
    next_cycle();
    expect_out("pending_done", ev(5'b00000, 3'b000, 1'b0, 2'd0));

    // Busy without redirect
    next_cycle(); ms_busy = 1'b1;
    expect_out("busy_np_c1", ev(5'b11110, 3'b000, 1'b0, 2'd0));
    next_cycle(); ms_busy = 1'b1;
    expect_out("busy_np_c2", ev(5'b11110, 3'b000, 1'b0, 2'd3));
    next_cycle();
    expect_out("busy_np_release", ev(5'b00000, 3'b000, 1'b0, 2'd3));
    next_cycle();
    expect_out("busy_np_run", ev(5'b00000, 3'b000, 1'b0, 2'd0));

    // Timeout after MEM_TIMEOUT=16 consecutive busy cycles
    for (int i = 1; i <= 16; i++) begin
      next_cycle(); ms_busy = 1'b1;
      if (i < 16)
        expect_out($sformatf("busy_long_%0d", i),
                   ev(5'b11110, 3'b000, 1'b0, (i == 1) ? 2'd0 : 2'd3));
      else
        expect_out("timeout_pulse", ev(5'b11100, 3'b001, 1'b1, 2'd3));
    end
    next_cycle();
    expect_out("after_timeout", ev(5'b00000, 3'b000, 1'b0, 2'd0));

    // ext_flush beats busy, redirect and hazard
    next_cycle(); ms_busy = 1'b1;
    expect_out("busy_before_xf", ev(5'b11110, 3'b000, 1'b0, 2'd0));
    next_cycle(); ext_flush = 1'b1; ms_busy = 1'b1; change_pc = 1'b1; load_use(5'd6, 5'd6, 5'd6);
    expect_out("ext_flush_priority", ev(5'b00000, 3'b111, 1'b0, 2'd3));
    next_cycle();
    expect_out("after_ext_flush", ev(5'b00000, 3'b000, 1'b0, 2'd0));

    // Asynchronous reset in the middle of FLUSH
    next_cycle(); change_pc = 1'b1;
    expect_out("redirect_4", ev(5'b00000, 3'b110, 1'b0, 2'd0));
    next_cycle(); #1 rst_n = 1'b0;
    expect_out("async_reset_mid_flush", ev(5'b00000, 3'b000, 1'b0, 2'd0));
    next_cycle(); rst_n = 1'b1;
    expect_out("run_after_reset", ev(5'b00000, 3'b000, 1'b0, 2'd0));
    next_cycle();
    expect_out("idle_final", ev(5'b00000, 3'b000, 1'b0, 2'd0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
